// File: rtl/conv_mac_sequencer.sv
// Loads a 3x3 pixel/weight window, drives it through an external combinational multiplier one tap per cycle, and outputs the sum.
// Optional build macro CONV_SAT_EN clamps out_sum to the product width (255 for DATA_W=4).
module conv_mac_sequencer #(
  parameter int DATA_W = 4,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pix,
  input  logic [DATA_W-1:0]   in_wgt,
  output logic                mul_start,
  output logic [DATA_W-1:0]   mul_din0,
  output logic [DATA_W-1:0]   mul_din1,
  input  logic [2*DATA_W-1:0] mul_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic                busy
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] pix [TAPS];
  logic [DATA_W-1:0] wgt [TAPS];
  logic              last_idx;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum_fmt;

  assign last_idx = (idx == IDX_W'(TAPS - 1));
  assign prod_ext = ACC_W'(mul_dout);

  // One shared index walks the taps both while loading and while multiplying.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      idx   <= '0;
      acc   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        pix[i] <= '0;
        wgt[i] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            pix[idx] <= in_pix;
            wgt[idx] <= in_wgt;
            if (last_idx) begin
              idx   <= '0;
              acc   <= '0;
              state <= ST_MAC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_MAC: begin
          acc <= acc + prod_ext;
          if (last_idx) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc   <= '0;
            state <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_LOAD;
          idx   <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

`ifdef CONV_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (2 * DATA_W)) - 1);
  assign sum_fmt = (acc > SAT_MAX) ? SAT_MAX : acc;
`else
  assign sum_fmt = acc;
`endif

  assign in_ready  = (state == ST_LOAD);
  assign mul_start = (state == ST_MAC);
  assign out_valid = (state == ST_DONE);
  assign busy      = mul_start | out_valid;

  // Operands and sum are forced to zero outside their owning state so idle buses stay quiet.
  assign mul_din0 = mul_start ? pix[idx] : '0;
  assign mul_din1 = mul_start ? wgt[idx] : '0;
  assign out_sum  = out_valid ? sum_fmt : '0;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer: directed windows plus randomized windows with input gaps and output stalls.
// The multiplier is modelled as a plain product; expected sums come from a dot-product reference model.
module tb_conv_mac_sequencer;

  localparam int DATA_W = 4;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   in_pix = '0;
  logic [DATA_W-1:0]   in_wgt = '0;
  logic                mul_start;
  logic [DATA_W-1:0]   mul_din0;
  logic [DATA_W-1:0]   mul_din1;
  logic [2*DATA_W-1:0] mul_dout;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACC_W-1:0]    out_sum;
  logic                busy;

  conv_mac_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_wgt    (in_wgt),
    .mul_start (mul_start),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign mul_dout = mul_din0 * mul_din1;

  int check_count = 0;
  int pass_count  = 0;
  logic [DATA_W-1:0] win_pix [TAPS];
  logic [DATA_W-1:0] win_wgt [TAPS];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference: dot product of the window, clamped to the product range when saturation is built in.
  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += int'(win_pix[i]) * int'(win_wgt[i]);
`ifdef CONV_SAT_EN
    if (s > (2 ** (2 * DATA_W)) - 1) s = (2 ** (2 * DATA_W)) - 1;
`endif
    return s;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWindow(input string name, input int gap_min, input int gap_max);
    for (int i = 0; i < TAPS; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, gap_min)) nextCycle();
      in_valid = 1'b1;
      in_pix   = win_pix[i];
      in_wgt   = win_wgt[i];
      checkOutput({name, ".in_ready"}, int'(in_ready), 1);
      nextCycle();
    end
    in_valid = 1'b0;
    in_pix   = '0;
    in_wgt   = '0;
  endtask

  task automatic applyStimulus(input string name, input int gap_min, input int gap_max, input int hold);
    int k;
    int cyc;
    int exp_sum;
    loadWindow(name, gap_min, gap_max);
    k = 0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (mul_start) begin
        if (k < TAPS) begin
          checkOutput({name, ".din0"}, int'(mul_din0), int'(win_pix[k]));
          checkOutput({name, ".din1"}, int'(mul_din1), int'(win_wgt[k]));
        end
        k++;
      end
      nextCycle();
      cyc++;
    end
    checkOutput({name, ".mac_cycles"}, k, TAPS);
    checkOutput({name, ".latency"}, cyc, TAPS);
    checkOutput({name, ".out_valid"}, int'(out_valid), 1);
    exp_sum = model_sum();
    checkOutput({name, ".out_sum"}, int'(out_sum), exp_sum);
    checkOutput({name, ".busy_done"}, int'(busy), 1);
    repeat (hold) begin
      out_ready = 1'b0;
      nextCycle();
      checkOutput({name, ".hold_valid"}, int'(out_valid), 1);
      checkOutput({name, ".hold_sum"}, int'(out_sum), exp_sum);
      checkOutput({name, ".hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    nextCycle();
    out_ready = 1'b0;
    checkOutput({name, ".post_valid"}, int'(out_valid), 0);
    checkOutput({name, ".post_in_ready"}, int'(in_ready), 1);
    checkOutput({name, ".post_busy"}, int'(busy), 0);
    checkOutput({name, ".post_start"}, int'(mul_start), 0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".in_ready"}, int'(in_ready), 1);
    checkOutput({name, ".mul_start"}, int'(mul_start), 0);
    checkOutput({name, ".mul_din0"}, int'(mul_din0), 0);
    checkOutput({name, ".mul_din1"}, int'(mul_din1), 0);
    checkOutput({name, ".out_valid"}, int'(out_valid), 0);
    checkOutput({name, ".out_sum"}, int'(out_sum), 0);
    checkOutput({name, ".busy"}, int'(busy), 0);
  endtask

  task automatic fillPattern(input int mode);
    for (int i = 0; i < TAPS; i++) begin
      case (mode)
        0: begin win_pix[i] = 4'd1;  win_wgt[i] = 4'd1;  end
        1: begin win_pix[i] = 4'd15; win_wgt[i] = 4'd15; end
        2: begin win_pix[i] = DATA_W'(i); win_wgt[i] = 4'd2; end
        3: begin win_pix[i] = 4'd2;  win_wgt[i] = 4'd3;  end
        default: begin
          win_pix[i] = DATA_W'($urandom_range(15, 0));
          win_wgt[i] = DATA_W'($urandom_range(15, 0));
        end
      endcase
    end
  endtask

  initial begin
    int k;
    int cyc;
    rst_n = 1'b0;
    repeat (3) nextCycle();
    checkResetValues("reset");
    rst_n = 1'b1;
    nextCycle();
    checkResetValues("idle");

    fillPattern(0);
    applyStimulus("ones", 0, 0, 0);
    checkOutput("ones.model", model_sum(), 9);
    fillPattern(1);
    applyStimulus("max", 0, 0, 0);
    fillPattern(2);
    applyStimulus("ramp", 0, 0, 0);
    checkOutput("ramp.model", model_sum(), 72);
    fillPattern(4);
    applyStimulus("stall", 0, 0, 5);

    // Abort a window in the middle of MAC and confirm nothing is emitted afterwards.
    fillPattern(4);
    loadWindow("abort", 0, 0);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      if (mul_start) k++;
      nextCycle();
      cyc++;
    end
    checkOutput("abort.tap4_active", int'(mul_start), 1);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkResetValues("abort");
    cyc = 0;
    repeat (12) begin
      if (out_valid || mul_start) cyc++;
      nextCycle();
    end
    checkOutput("abort.no_output", cyc, 0);
    fillPattern(3);
    applyStimulus("after_abort", 0, 0, 0);
    checkOutput("after_abort.model", model_sum(), 54);

    fillPattern(0);
    applyStimulus("gap_ones", 1, 3, 0);
    fillPattern(1);
    applyStimulus("gap_max", 1, 3, 1);
    fillPattern(2);
    applyStimulus("gap_ramp", 1, 3, 2);

    for (int n = 0; n < 8; n++) begin
      fillPattern(4);
      applyStimulus("rand", 0, 3, int'($urandom_range(3, 0)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
